tdm_mux: RTL and testbench

Two-channel time-division multiplexer that merges two valid/ready input streams onto one tagged output stream. It is the transmit-side counterpart of the 1:2 demux: its `S` tag uses the same convention, so a demux receiving `S` steers each beat back to its original channel (`S`=0 to `O1`, `S`=1 to `O2`). Arbitration is round-robin. The output is a single registered stage with a full valid/ready handshake.

---
 rtl/tdm_mux.sv | 131 +++++++++++++
 tb/tb_tdm_mux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux.sv
// tdm_mux: two-channel time-division multiplexer.
// Merges two valid/ready streams onto one registered, tagged output stream.
// S=0 marks a beat from channel 1, S=1 a beat from channel 2.
// Optional macro TDM_MUX_PRIORITY_EN: when defined, channel 1 always wins
// contention and no last-served state is kept; otherwise arbitration is
// round-robin.
module tdm_mux #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I1,
  input  logic             V1,
  output logic             R1,
  input  logic [WIDTH-1:0] I2,
  input  logic             V2,
  output logic             R2,
  output logic [WIDTH-1:0] O,
  output logic             S,
  output logic             V,
  input  logic             R
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_data;
  logic             r_tag;

  logic             w_full;
  logic             w_load;
  logic             w_grant1;
  logic             w_grant2;
  logic             w_accept1;
  logic             w_accept2;
  logic             w_acceptAny;

  assign w_full      = (r_state == ST_FULL);
  assign w_load      = ~w_full | R;
  assign w_accept1   = R1 & V1;
  assign w_accept2   = R2 & V2;
  assign w_acceptAny = w_accept1 | w_accept2;

`ifdef TDM_MUX_PRIORITY_EN
  // Fixed priority: channel 1 wins whenever it is valid.
  always_comb begin
    w_grant1 = V1;
    w_grant2 = V2 & ~V1;
  end
`else
  logic r_last;

  // Remember which channel was served last; reset to 1 so ch1 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last <= 1'b1;
    end else if (w_accept1) begin
      r_last <= 1'b0;
    end else if (w_accept2) begin
      r_last <= 1'b1;
    end
  end

  // Round-robin grant: on contention serve the channel not served last.
  always_comb begin
    w_grant1 = 1'b0;
    w_grant2 = 1'b0;
    if (V1 && V2) begin
      w_grant1 = r_last;
      w_grant2 = ~r_last;
    end else begin
      w_grant1 = V1;
      w_grant2 = V2;
    end
  end
`endif

  // Output-stage state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: fill on accept, drain when consumed without a replacement.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_acceptAny) begin
          w_stateNext = ST_FULL;
        end
      end
      ST_FULL: begin
        if (R && !w_acceptAny) begin
          w_stateNext = ST_EMPTY;
        end
      end
    endcase
  end

  // Data and tag register; loads only on an accepted beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data <= '0;
      r_tag  <= 1'b0;
    end else if (w_accept1) begin
      r_data <= I1;
      r_tag  <= 1'b0;
    end else if (w_accept2) begin
      r_data <= I2;
      r_tag  <= 1'b1;
    end
  end

  // Outputs: registered data/tag/valid, readies gated off while in reset.
  always_comb begin
    O  = r_data;
    S  = r_tag;
    V  = w_full;
    R1 = w_load & w_grant1 & ~RST;
    R2 = w_load & w_grant2 & ~RST;
  end

endmodule

// File: tb/tb_tdm_mux.sv
// tb_tdm_mux: directed self-checking bench for tdm_mux.
// Expected values are hand-computed; honours TDM_MUX_PRIORITY_EN if defined.
module tb_tdm_mux;

  logic       CLK;
  logic       RST;
  logic [7:0] I1;
  logic       V1;
  logic       R1;
  logic [7:0] I2;
  logic       V2;
  logic       R2;
  logic [7:0] O;
  logic       S;
  logic       V;
  logic       R;

  int testsRun;
  int testsFailed;

  tdm_mux #(.WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .I1 (I1),
    .V1 (V1),
    .R1 (R1),
    .I2 (I2),
    .V2 (V2),
    .R2 (R2),
    .O  (O),
    .S  (S),
    .V  (V),
    .R  (R)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive every input of the DUT in one step.
  task automatic applyStimulus(input logic v1, input logic [7:0] i1,
                               input logic v2, input logic [7:0] i2,
                               input logic r);
    V1 = v1;
    I1 = i1;
    V2 = v2;
    I2 = i2;
    R  = r;
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reset with idle inputs, release away from any edge.
  task automatic doReset();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  // Check the registered output triple.
  task automatic checkBeat(input string tag, input logic [7:0] o,
                           input logic s, input logic v);
    checkOutput({tag, ".O"}, 32'(O), 32'(o));
    checkOutput({tag, ".S"}, 32'(S), 32'(s));
    checkOutput({tag, ".V"}, 32'(V), 32'(v));
  endtask

  logic [7:0] streamData [3];
  logic       expTag;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    streamData[0] = 8'h11;
    streamData[1] = 8'h22;
    streamData[2] = 8'h33;

    // Reset with both channels valid: everything quiet, no readies.
    RST = 1'b1;
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    tick();
    tick();
    checkBeat("rst", 8'h00, 1'b0, 1'b0);
    checkOutput("rst.R1", 32'(R1), 32'd0);
    checkOutput("rst.R2", 32'(R2), 32'd0);
    RST = 1'b0;
    #1;
    checkOutput("rel.R1", 32'(R1), 32'd1);
    checkOutput("rel.R2", 32'(R2), 32'd0);
    tick();
    checkBeat("rel.first", 8'h11, 1'b0, 1'b1);

    // Single-channel streaming with one-cycle latency.
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, streamData[k], 1'b0, 8'h00, 1'b1);
      tick();
      checkBeat($sformatf("stream%0d", k), streamData[k], 1'b0, 1'b1);
    end

    // Bubble: one beat, then nothing valid; valid drops one cycle later.
    doReset();
    applyStimulus(1'b1, 8'h7E, 1'b0, 8'h00, 1'b1);
    tick();
    checkBeat("bubble.load", 8'h7E, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("bubble.V", 32'(V), 32'd0);

    // Continuous contention.
    doReset();
    applyStimulus(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
    for (int k = 0; k < 6; k++) begin
`ifdef TDM_MUX_PRIORITY_EN
      expTag = 1'b0;
`else
      expTag = (k % 2 == 1);
`endif
      checkOutput($sformatf("cont%0d.R2", k), 32'(R2), 32'(expTag));
      tick();
      checkBeat($sformatf("cont%0d", k), expTag ? 8'hB0 : 8'hA0, expTag, 1'b1);
    end

    // Backpressure: hold a ch2 beat while both channels wait.
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
    tick();
    checkBeat("bp.load", 8'h5A, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'hC3, 1'b1, 8'h66, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("bp%0d.R1", k), 32'(R1), 32'd0);
      checkOutput($sformatf("bp%0d.R2", k), 32'(R2), 32'd0);
      tick();
      checkBeat($sformatf("bp%0d", k), 8'h5A, 1'b1, 1'b1);
    end
    R = 1'b1;
    #1;
    checkOutput("bp.rel.R1", 32'(R1), 32'd1);
    tick();
    checkBeat("bp.rel", 8'hC3, 1'b0, 1'b1);

    // Reset pulsed between edges while full and stalled.
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h44, 1'b1);
    tick();
    checkBeat("rf.load", 8'h44, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    RST = 1'b1;
    #1;
    checkBeat("rf.async", 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
    applyStimulus(1'b1, 8'h99, 1'b1, 8'hAA, 1'b1);
    #1;
    checkOutput("rf.R1", 32'(R1), 32'd1);
    tick();
    checkBeat("rf.next", 8'h99, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
